// File: rtl/uart_rx_frame_check.sv
// Receive-side UART frame checker: assembles start/data/parity/stop from mid-bit strobes,
// publishes the byte with a one-cycle valid pulse, and flags parity and framing errors.
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_bit_i,
  input  logic                  bit_strb_i,
  input  logic                  par_en_i,
  input  logic                  par_typ_i,
  output logic [DATA_WIDTH-1:0] p_data_o,
  output logic                  data_valid_o,
  output logic                  par_err_o,
  output logic                  stp_err_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pen_q, pen_d;
  logic                    ptyp_q, ptyp_d;
  logic                    rxpar_q, rxpar_d;
  logic                    dv_q, dv_d;
  logic                    pe_q, pe_d;
  logic                    se_q, se_d;
  logic                    exp_par;
  logic                    par_bad;
  logic                    last_data;

  // Parity settings come from the values latched at the start bit, not the live inputs.
  assign exp_par   = ptyp_q ? (^shift_q) : ~(^shift_q);
  assign par_bad   = pen_q & (rxpar_q != exp_par);
  assign last_data = (cnt_q == CW'(DATA_WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    p_data_d = p_data_q;
    cnt_d    = cnt_q;
    pen_d    = pen_q;
    ptyp_d   = ptyp_q;
    rxpar_d  = rxpar_q;
    dv_d     = 1'b0;
    pe_d     = 1'b0;
    se_d     = 1'b0;
    if (bit_strb_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_bit_i) begin
            state_d = S_DATA;
            pen_d   = par_en_i;
            ptyp_d  = par_typ_i;
            shift_d = '0;
            cnt_d   = '0;
            rxpar_d = 1'b0;
          end
        end
        S_DATA: begin
          shift_d = {rx_bit_i, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (last_data) state_d = pen_q ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          rxpar_d = rx_bit_i;
          state_d = S_STOP;
        end
        S_STOP: begin
          pe_d = par_bad;
          se_d = ~rx_bit_i;
          dv_d = rx_bit_i & ~par_bad;
          if (rx_bit_i && !par_bad) p_data_d = shift_q;
          state_d = rx_bit_i ? S_IDLE : S_BRK;
        end
        S_BRK: begin
          if (rx_bit_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      p_data_q <= '0;
      cnt_q    <= '0;
      pen_q    <= 1'b0;
      ptyp_q   <= 1'b0;
      rxpar_q  <= 1'b0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      p_data_q <= p_data_d;
      cnt_q    <= cnt_d;
      pen_q    <= pen_d;
      ptyp_q   <= ptyp_d;
      rxpar_q  <= rxpar_d;
      dv_q     <= dv_d;
      pe_q     <= pe_d;
      se_q     <= se_d;
    end
  end

  assign p_data_o     = p_data_q;
  assign data_valid_o = dv_q;
  assign par_err_o    = pe_q;
  assign stp_err_o    = se_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check: hand-built frames, immediate-assertion checks.
module tb_uart_rx_frame_check;

  logic       clk = 1'b0;
  logic       rst, rx_bit, bit_strb, par_en, par_typ;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;
  int         checks = 0;
  int         errors = 0;

  uart_rx_frame_check #(.DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .rx_bit_i(rx_bit), .bit_strb_i(bit_strb),
    .par_en_i(par_en), .par_typ_i(par_typ), .p_data_o(p_data),
    .data_valid_o(data_valid), .par_err_o(par_err), .stp_err_o(stp_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bits, bit 0 first on the wire: start, data LSB first, [parity], stop.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic pen,
                                     input logic pbit, input logic stop);
    if (pen) return {stop, pbit, d, 1'b0};
    return {1'b0, stop, d, 1'b0};
  endfunction

  task automatic sbit(input logic b);
    @(negedge clk);
    bit_strb = 1'b1;
    rx_bit   = b;
  endtask

  task automatic idle();
    @(negedge clk);
    bit_strb = 1'b0;
    rx_bit   = 1'b1;
  endtask

  // Sends bits [first..n-1] on consecutive cycles; par_en flips when bit index tog is sent.
  task automatic sframe(input logic [10:0] b, input int n, input int first, input int tog);
    for (int i = first; i < n; i++) begin
      if (i == tog) par_en = ~par_en;
      sbit(b[i]);
    end
  endtask

  task automatic outs(input string tag, input logic dv, input logic pe, input logic se,
                      input logic bz, input logic [7:0] pd);
    chk({tag, ".dv"}, 32'(data_valid), 32'(dv));
    chk({tag, ".pe"}, 32'(par_err), 32'(pe));
    chk({tag, ".se"}, 32'(stp_err), 32'(se));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".pdata"}, 32'(p_data), 32'(pd));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rx_bit = 1'b1; bit_strb = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    outs("reset", 0, 0, 0, 0, 8'h00);

    // 8N1 0xA5
    par_en = 0;
    sframe(mk(8'hA5, 0, 0, 1), 10, 0, 99);
    idle();
    outs("8n1_a5", 1, 0, 0, 0, 8'hA5);
    idle();
    outs("8n1_a5_after", 0, 0, 0, 0, 8'hA5);

    // 8O1 0x00 parity 1 -> valid
    par_en = 1; par_typ = 0;
    sframe(mk(8'h00, 1, 1, 1), 11, 0, 99);
    idle();
    outs("8o1_00_ok", 1, 0, 0, 0, 8'h00);

    // 8E1 0xA5 parity 1 -> par_err, p_data holds 0x00
    par_typ = 1;
    sframe(mk(8'hA5, 1, 1, 1), 11, 0, 99);
    idle();
    outs("8e1_a5_bad", 0, 1, 0, 0, 8'h00);
    idle();
    outs("8e1_a5_bad_after", 0, 0, 0, 0, 8'h00);

    // 8E1 0xA5 parity 0 -> valid
    sframe(mk(8'hA5, 1, 0, 1), 11, 0, 99);
    idle();
    outs("8e1_a5_ok", 1, 0, 0, 0, 8'hA5);

    // 8O1 0x00 parity 0 -> par_err
    par_typ = 0;
    sframe(mk(8'h00, 1, 0, 1), 11, 0, 99);
    idle();
    outs("8o1_00_bad", 0, 1, 0, 0, 8'hA5);

    // 8N1 0x3C with stop 0, then line held low
    par_en = 0;
    sframe(mk(8'h3C, 0, 0, 0), 3, 0, 99);
    idle();
    chk("stp.busy_mid", 32'(busy), 32'd1);
    sframe(mk(8'h3C, 0, 0, 0), 10, 3, 99);
    idle();
    outs("stp_err", 0, 0, 1, 1, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      sbit(1'b0);
      idle();
      outs("brk_low", 0, 0, 0, 1, 8'hA5);
    end
    sbit(1'b1);
    idle();
    outs("brk_release", 0, 0, 0, 0, 8'hA5);

    // Reset after the 4th data strobe aborts the frame
    sframe(mk(8'hFF, 0, 0, 1), 5, 0, 99);
    @(negedge clk);
    bit_strb = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outs("abort_rst", 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      idle();
      outs("abort_quiet", 0, 0, 0, 0, 8'h00);
    end
    sframe(mk(8'h5A, 0, 0, 1), 10, 0, 99);
    idle();
    outs("after_abort_5a", 1, 0, 0, 0, 8'h5A);

    // Back-to-back, strobe every cycle, par_en toggled mid-frame
    par_en = 1; par_typ = 1;
    sframe(mk(8'h81, 1, 0, 1), 11, 0, 4);   // latched 8E1, par_en drops at bit 4
    par_en = 0;
    sbit(1'b0);                              // start of next frame, no dead cycle
    outs("b2b_first", 1, 0, 0, 0, 8'h81);
    sframe(mk(8'h7E, 0, 0, 1), 10, 1, 5);   // latched 8N1, par_en rises at bit 5
    idle();
    outs("b2b_second", 1, 0, 0, 0, 8'h7E);
    idle();
    outs("b2b_quiet", 0, 0, 0, 0, 8'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
